keccak_pad_pack: RTL and testbench
==================================

KECCAK_PAD_PACK -- requirements
Module: keccak_pad_pack

Interface
REQ-001 SHALL have parameter DW, default 32, input word width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter RMAX, fixed 1152, block output width in bits (largest rate).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 mode  input  2  0=SHA3-224 (rate 144 B), 1=SHA3-256 (136 B), 2=SHA3-384 (104 B), 3=SHA3-512 (72 B).
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_data  input  DW  message word; bits [DW-1:DW-8] are the earliest message byte.
REQ-009 in_last  input  1  marks the final word of a message.
REQ-010 in_bytes  input  clog2(DW/8)+1  valid bytes in the last word, 0..DW/8; ignored unless in_last.
REQ-011 abort  input  1  synchronous discard of the current message.
REQ-012 blk_valid  output  1  blk_data holds a complete rate block.
REQ-013 blk_ready  input  1  consumer takes the block this cycle.
REQ-014 blk_data  output  RMAX  block; message byte k at bits [8k+7:8k]; bits above rate are 0.
REQ-015 blk_last  output  1  this block is the final block of the message.
REQ-016 blk_mode  output  2  mode latched for the message carrying this block.

Function
REQ-017 SHALL implement states FILL, PAD and HOLD.
REQ-018 A word SHALL be accepted when in_valid && in_ready; in_ready SHALL be 1 only in FILL.
REQ-019 mode SHALL be latched on acceptance of the first word of a message; changes mid-message SHALL be ignored.
REQ-020 Each accepted word SHALL be written at word index wcnt of the buffer, and wcnt SHALL increment. Word count per block = rate/(DW/8): 36/34/26/18 for DW=32 and 18/17/13/9 for DW=64.
REQ-021 Non-last word filling the final index: FILL->HOLD with blk_last=0 and wcnt cleared.
REQ-022 Last word with byte position p = wcnt*(DW/8)+in_bytes < rate: FILL->PAD, and bytes at and above p in the written word SHALL be forced to 0.
REQ-023 Last word with p == rate: FILL->HOLD with blk_last=0 and pad_pend set; after handoff, HOLD->PAD on an all-zero buffer with p=0.
REQ-024 PAD SHALL last exactly one cycle, OR 0x06 into byte p and 0x80 into byte rate-1 (0x86 when p==rate-1), then go to HOLD with blk_last=1.
REQ-025 In HOLD, blk_valid=1 and blk_data, blk_last and blk_mode SHALL stay stable until blk_ready.
REQ-026 On HOLD handoff, the buffer SHALL be cleared. With pad_pend set, the next state SHALL be PAD; otherwise it SHALL be FILL, and in_ready SHALL be 1 the next cycle.
REQ-027 Latency: blk_valid SHALL rise 1 cycle after the completing word for full blocks, and 2 cycles after the last word for padded blocks.
REQ-028 abort SHALL take priority over every other input in every state. It SHALL clear the buffer, wcnt, pad_pend and blk_valid, and the next state SHALL be FILL. A word presented in the same cycle SHALL be dropped.
REQ-029 A handshake in a cycle with blk_ready=1 and blk_valid=0 SHALL have no effect.

Reset
REQ-030 While rst=1, the block SHALL be in state FILL with in_ready=1, blk_valid=0, blk_data=0, blk_last=0, blk_mode=0, and wcnt and pad_pend cleared.
REQ-031 Reset asserted mid-message or in HOLD SHALL discard all buffered data; no partial block SHALL be emitted after release.

Verification
REQ-032 DW=32, mode=3, "The quick brown fox jumps over the lazy dog." as 11 full words, then a word with in_last=1, in_bytes=0 -> one block: bytes 0..43 equal the message, byte44=0x06, byte71=0x80, bytes 45..70 and 72+ are 0, blk_last=1.
REQ-033 Empty message (single word, in_last=1, in_bytes=0), mode=1 -> byte0=0x06, byte135=0x80, blk_last=1; with mode=3 -> byte71=0x80 instead.
REQ-034 DW=32, mode=3, 18 full words with in_last on the 18th and in_bytes=4 -> first block holds the message with blk_last=0; second block has byte0=0x06, byte71=0x80 and blk_last=1.
REQ-035 DW=64, mode=3, 9 words with the last word in_bytes=7 (71 bytes) -> byte71=0x86 and blk_last=1.
REQ-036 Hold blk_ready=0 for 5 cycles in HOLD -> in_ready=0 and blk_data unchanged throughout; with mode toggled during the hold, blk_mode remains the latched value.
REQ-037 abort asserted together with in_valid at word 5 -> no block is emitted; the next message's first block is uncontaminated by the aborted words.

Source files
------------

// File: rtl/keccak_pad_pack.sv
// SHA-3 message packer: gathers DW-bit words into a rate-sized block and applies
// the SHA-3 domain/multi-rate padding (0x06 ... 0x80) on the final block.
module keccak_pad_pack #(
    parameter int DW   = 32,
    parameter int RMAX = 1152
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    input  logic                     in_last,
    input  logic [$clog2(DW/8):0]    in_bytes,
    input  logic                     abort,
    output logic                     blk_valid,
    input  logic                     blk_ready,
    output logic [RMAX-1:0]          blk_data,
    output logic                     blk_last,
    output logic [1:0]               blk_mode
);
    localparam int BW  = DW / 8;
    localparam int BSH = $clog2(BW);

    typedef enum logic [1:0] {FILL, PAD, HOLD} state_t;

    state_t            state, state_n;
    logic [RMAX-1:0]   data_q, data_n;
    logic [5:0]        wcnt, wlast;
    logic [7:0]        pos, cur_rate, rate_q, bi;
    logic [8:0]        p;
    logic [1:0]        mode_q, cur_mode;
    logic              pad_pend, in_msg, last_q;
    logic              acc, word_full, last_pad, last_full;

    function automatic logic [7:0] rate_of(input logic [1:0] m);
        case (m)
            2'd0:    rate_of = 8'd144;
            2'd1:    rate_of = 8'd136;
            2'd2:    rate_of = 8'd104;
            default: rate_of = 8'd72;
        endcase
    endfunction

    // The first word of a message sees the live mode; later words use the latched one.
    always_comb begin
        cur_mode  = in_msg ? mode_q : mode;
        cur_rate  = rate_of(cur_mode);
        rate_q    = rate_of(mode_q);
        wlast     = 6'((cur_rate >> BSH) - 8'd1);
        p         = 9'(wcnt) * 9'(BW) + 9'(in_bytes);
        acc       = in_valid && (state == FILL) && !abort;
        word_full = acc && !in_last && (wcnt == wlast);
        last_pad  = acc && in_last && (p < {1'b0, cur_rate});
        last_full = acc && in_last && !last_pad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = FILL;
        end else begin
            case (state)
                FILL: begin
                    if (word_full || last_full) state_n = HOLD;
                    else if (last_pad)          state_n = PAD;
                end
                PAD:  state_n = HOLD;
                HOLD: if (blk_ready) state_n = pad_pend ? PAD : FILL;
                default: state_n = FILL;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == FILL);
        blk_valid = (state == HOLD);
    end

    // Bytes past in_bytes in the last word are zeroed so the pad lands on clean bytes.
    always_comb begin
        data_n = data_q;
        bi     = '0;
        if (abort) begin
            data_n = '0;
        end else if (acc) begin
            for (int j = 0; j < BW; j++) begin
                bi = 8'(wcnt) * 8'(BW) + 8'(j);
                data_n[{bi, 3'b000} +: 8] = (in_last && (j >= int'(in_bytes))) ?
                                            8'h00 : in_data[DW-1-8*j -: 8];
            end
        end else if (state == PAD) begin
            data_n[{pos, 3'b000} +: 8]             = data_n[{pos, 3'b000} +: 8] | 8'h06;
            data_n[{rate_q - 8'd1, 3'b000} +: 8]   = data_n[{rate_q - 8'd1, 3'b000} +: 8] | 8'h80;
        end else if ((state == HOLD) && blk_ready) begin
            data_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '0;
            wcnt     <= '0;
            pos      <= '0;
            pad_pend <= 1'b0;
            in_msg   <= 1'b0;
            last_q   <= 1'b0;
            mode_q   <= 2'd0;
        end else begin
            data_q <= data_n;
            if (abort) begin
                wcnt     <= '0;
                pad_pend <= 1'b0;
                in_msg   <= 1'b0;
                last_q   <= 1'b0;
            end else if (acc) begin
                if (!in_msg) mode_q <= mode;
                if (in_last) begin
                    wcnt     <= '0;
                    in_msg   <= 1'b0;
                    pos      <= p[7:0];
                    pad_pend <= last_full;
                    last_q   <= 1'b0;
                end else begin
                    in_msg <= 1'b1;
                    if (word_full) begin
                        wcnt   <= '0;
                        last_q <= 1'b0;
                    end else begin
                        wcnt <= wcnt + 6'd1;
                    end
                end
            end else if (state == PAD) begin
                last_q <= 1'b1;
            end else if ((state == HOLD) && blk_ready && pad_pend) begin
                pos      <= '0;
                pad_pend <= 1'b0;
            end
        end
    end

    assign blk_data = data_q;
    assign blk_last = last_q;
    assign blk_mode = mode_q;
endmodule

// File: tb/tb_keccak_pad_pack.sv
// Directed bench for keccak_pad_pack: table of messages with hand-set block counts
// and pad positions, plus sequences for hold, latency, abort, reset and DW=64.
module tb_keccak_pad_pack;
    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     mode;
    logic           in_valid, in_ready, in_last, abort;
    logic [31:0]    in_data;
    logic [2:0]     in_bytes;
    logic           blk_valid, blk_ready, blk_last;
    logic [1151:0]  blk_data;
    logic [1:0]     blk_mode;

    logic [1:0]     mode64;
    logic           in_valid64, in_ready64, in_last64, abort64;
    logic [63:0]    in_data64;
    logic [3:0]     in_bytes64;
    logic           blk_valid64, blk_ready64, blk_last64;
    logic [1151:0]  blk_data64;
    logic [1:0]     blk_mode64;

    always #5 clk = ~clk;

    keccak_pad_pack #(.DW(32)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes), .abort(abort),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_last(blk_last), .blk_mode(blk_mode));

    keccak_pad_pack #(.DW(64)) dut64 (
        .clk(clk), .rst(rst), .mode(mode64), .in_valid(in_valid64), .in_ready(in_ready64),
        .in_data(in_data64), .in_last(in_last64), .in_bytes(in_bytes64), .abort(abort64),
        .blk_valid(blk_valid64), .blk_ready(blk_ready64), .blk_data(blk_data64),
        .blk_last(blk_last64), .blk_mode(blk_mode64));

    typedef struct {
        logic [1151:0] data;
        logic          last;
        logic [1:0]    mode;
    } blk_t;

    typedef struct {
        logic [1:0] mode;
        int         len;
        bit         tail;
        bit         fox;
        int         rate;
        int         nblk;
        int         p;
    } vec_t;

    blk_t          exp_q[$];
    vec_t          vt[8];
    logic [7:0]    msg[0:511];
    int            n_vec = 0;
    int            n_err = 0;
    logic [1151:0] snap, e64;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [1151:0] act, input logic [1151:0] exp);
        int first;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            first = -1;
            for (int k = 143; k >= 0; k--)
                if (act[k*8 +: 8] !== exp[k*8 +: 8]) first = k;
            $display("FAIL %s: byte %0d got %02h want %02h", name, first,
                     act[first*8 +: 8], exp[first*8 +: 8]);
        end
    endtask

    always @(negedge clk) begin
        blk_t e;
        if (!rst && blk_valid && blk_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_blk", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk_blk("blk_data", blk_data, e.data);
                chk("blk_last", 64'(blk_last), 64'(e.last));
                chk("blk_mode", 64'(blk_mode), 64'(e.mode));
            end
        end
    end

    function automatic logic [31:0] word_at(input int base, input int len);
        logic [31:0] w;
        for (int j = 0; j < 4; j++)
            w[31-8*j -: 8] = (base + j < len) ? msg[base + j] : 8'hEE;
        return w;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int t;
        in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Mode is flipped after the first word to confirm it is latched per message.
    task automatic send_msg(input logic [1:0] m, input int len, input bit tail);
        int nw, rem;
        bit full_last;
        nw = len / 4; rem = len % 4;
        full_last = (rem == 0) && !tail && (len > 0);
        mode = m;
        for (int w = 0; w < nw; w++) begin
            send_word(word_at(4*w, len), full_last && (w == nw - 1), 3'd4);
            if (w == 0) mode = ~m;
        end
        if (!full_last) send_word(word_at(4*nw, len), 1'b1, 3'(rem));
    endtask

    task automatic push_exp(input logic [1:0] m, input int rate, input int nblk, input int p);
        blk_t e;
        int nb;
        for (int b = 0; b < nblk; b++) begin
            e.data = '0;
            nb = (b < nblk - 1) ? rate : p;
            for (int k = 0; k < nb; k++) e.data[k*8 +: 8] = msg[b*rate + k];
            if (b == nblk - 1) begin
                e.data[p*8 +: 8]        = e.data[p*8 +: 8] | 8'h06;
                e.data[(rate-1)*8 +: 8] = e.data[(rate-1)*8 +: 8] | 8'h80;
            end
            e.last = (b == nblk - 1);
            e.mode = m;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        string fox;
        fox = "The quick brown fox jumps over the lazy dog.";
        rst = 1'b1; mode = 2'd0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_bytes = '0; abort = 1'b0; blk_ready = 1'b1;
        mode64 = 2'd3; in_valid64 = 1'b0; in_data64 = '0; in_last64 = 1'b0;
        in_bytes64 = '0; abort64 = 1'b0; blk_ready64 = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_blk_valid", 64'(blk_valid), 64'd0);
        chk_blk("rst_blk_data", blk_data, '0);
        chk("rst_blk_last", 64'(blk_last), 64'd0);
        chk("rst_blk_mode", 64'(blk_mode), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        //          mode  len  tail fox rate nblk p
        vt[0] = '{2'd3,  44, 1'b1, 1'b1,  72, 1,  44};
        vt[1] = '{2'd1,   0, 1'b1, 1'b0, 136, 1,   0};
        vt[2] = '{2'd3,   0, 1'b1, 1'b0,  72, 1,   0};
        vt[3] = '{2'd3,  72, 1'b0, 1'b0,  72, 2,   0};
        vt[4] = '{2'd0, 150, 1'b0, 1'b0, 144, 2,   6};
        vt[5] = '{2'd2, 103, 1'b0, 1'b0, 104, 1, 103};
        vt[6] = '{2'd1,   5, 1'b0, 1'b0, 136, 1,   5};
        vt[7] = '{2'd2, 208, 1'b1, 1'b0, 104, 3,   0};

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 512; k++) msg[k] = 8'(i*37 + k + 1);
            if (vt[i].fox) for (int k = 0; k < 44; k++) msg[k] = fox[k];
            push_exp(vt[i].mode, vt[i].rate, vt[i].nblk, vt[i].p);
            send_msg(vt[i].mode, vt[i].len, vt[i].tail);
            drain();
        end

        // Padded latency, hold stability and blk_mode latching under a mode change.
        blk_ready = 1'b0;
        for (int k = 0; k < 5; k++) msg[k] = 8'hA0 + 8'(k);
        push_exp(2'd3, 72, 1, 5);
        send_msg(2'd3, 5, 1'b0);
        @(negedge clk);
        chk("pad_lat_1", 64'(blk_valid), 64'd0);
        @(negedge clk);
        chk("pad_lat_2", 64'(blk_valid), 64'd1);
        snap = blk_data;
        mode = 2'd1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_valid", 64'(blk_valid), 64'd1);
            chk_blk("hold_data", blk_data, snap);
            chk("hold_mode", 64'(blk_mode), 64'd3);
        end
        @(posedge clk); #1;
        blk_ready = 1'b1;
        drain();

        // Full block is visible right after the completing word.
        blk_ready = 1'b0;
        for (int k = 0; k < 72; k++) msg[k] = 8'h30 + 8'(k);
        push_exp(2'd3, 72, 2, 0);
        send_msg(2'd3, 72, 1'b0);
        @(negedge clk);
        chk("full_lat", 64'(blk_valid), 64'd1);
        @(posedge clk); #1;
        blk_ready = 1'b1;
        drain();

        // Abort together with word 5; the next message must not see old bytes.
        for (int k = 0; k < 16; k++) msg[k] = 8'hC0 + 8'(k);
        mode = 2'd3;
        for (int w = 0; w < 4; w++) send_word(word_at(4*w, 16), 1'b0, 3'd4);
        in_valid = 1'b1; abort = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; abort = 1'b0;
        for (int k = 0; k < 16; k++) msg[k] = 8'h50 + 8'(k);
        push_exp(2'd3, 72, 1, 10);
        send_msg(2'd3, 10, 1'b0);
        drain();

        // Abort while holding a block drops it and clears the buffer.
        blk_ready = 1'b0;
        for (int k = 0; k < 4; k++) msg[k] = 8'hF0 + 8'(k);
        send_msg(2'd1, 3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_hold_pre", 64'(blk_valid), 64'd1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_hold_valid", 64'(blk_valid), 64'd0);
        chk("abort_hold_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        blk_ready = 1'b1;
        msg[0] = 8'h11; msg[1] = 8'h22;
        push_exp(2'd1, 136, 1, 2);
        send_msg(2'd1, 2, 1'b0);
        drain();

        // Reset mid-message discards the partial block.
        for (int k = 0; k < 12; k++) msg[k] = 8'h70 + 8'(k);
        for (int w = 0; w < 3; w++) send_word(word_at(4*w, 12), 1'b0, 3'd4);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_valid", 64'(blk_valid), 64'd0);
        chk_blk("mid_rst_data", blk_data, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) msg[k] = 8'h90 + 8'(k);
        push_exp(2'd0, 144, 1, 6);
        send_msg(2'd0, 6, 1'b0);
        drain();

        // DW=64, 71-byte message in mode 3: both pad bytes share byte 71.
        for (int k = 0; k < 71; k++) msg[k] = 8'(k + 1);
        for (int w = 0; w < 9; w++) begin
            for (int j = 0; j < 8; j++)
                in_data64[63-8*j -: 8] = (8*w + j < 71) ? msg[8*w + j] : 8'hEE;
            in_valid64 = 1'b1; in_last64 = (w == 8); in_bytes64 = (w == 8) ? 4'd7 : 4'd8;
            @(posedge clk); #1;
        end
        in_valid64 = 1'b0; in_last64 = 1'b0;
        for (int t = 0; t < 20 && !blk_valid64; t++) @(negedge clk);
        chk("dw64_valid", 64'(blk_valid64), 64'd1);
        e64 = '0;
        for (int k = 0; k < 71; k++) e64[k*8 +: 8] = msg[k];
        e64[71*8 +: 8] = 8'h86;
        chk_blk("dw64_data", blk_data64, e64);
        chk("dw64_byte71", 64'(blk_data64[71*8 +: 8]), 64'h86);
        chk("dw64_last", 64'(blk_last64), 64'd1);
        chk("dw64_mode", 64'(blk_mode64), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
